// File: rtl/ika9958_reg_access_ctrl.sv
// CPU port decoder for the VDP register file, VRAM address setup, indirect port and palette.
// Optional palette path is enabled by defining IKA9958_PALETTE_EN.
module ika9958_reg_access_ctrl (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_WR_STB,
  input  logic        i_RD_STB,
  input  logic [1:0]  i_PORT,
  input  logic [7:0]  i_DIN,
  output logic        o_REG_WE,
  output logic [5:0]  o_REG_ADDR,
  output logic [7:0]  o_REG_WDATA,
  output logic        o_VADDR_STB,
  output logic [13:0] o_VADDR,
  output logic        o_VADDR_WR,
  output logic        o_PAL_WE,
  output logic [3:0]  o_PAL_IDX,
  output logic [8:0]  o_PAL_DATA,
  output logic [3:0]  o_R16,
  output logic [7:0]  o_R17
);

  typedef enum logic {P1_IDLE, P1_HAVE1} p1State_e;

  p1State_e    p1State_q, p1State_d;
  logic [7:0]  p1Latch_q, p1Latch_d;
  logic        regWe_q, regWe_d;
  logic [5:0]  regAddr_q, regAddr_d;
  logic [7:0]  regWdata_q, regWdata_d;
  logic        vaddrStb_q, vaddrStb_d;
  logic [13:0] vaddr_q, vaddr_d;
  logic        vaddrWr_q, vaddrWr_d;
  logic [3:0]  r16_q, r16_d;
  logic [7:0]  r17_q, r17_d;

  logic        wrEn, rdEn;
  logic        regReq;
  logic [5:0]  regIdx;
  logic [7:0]  regData;

`ifdef IKA9958_PALETTE_EN
  typedef enum logic {PL_IDLE, PL_HAVE1} plState_e;

  plState_e    plState_q, plState_d;
  logic [5:0]  palLatch_q, palLatch_d;
  logic        palWe_q, palWe_d;
  logic [3:0]  palIdx_q, palIdx_d;
  logic [8:0]  palData_q, palData_d;
`endif

  // A write wins over a simultaneous read, so reads only act when no write is present.
  assign wrEn = i_WR_STB;
  assign rdEn = i_RD_STB & ~i_WR_STB;

  always_comb begin
    p1State_d  = p1State_q;
    p1Latch_d  = p1Latch_q;
    regWe_d    = 1'b0;
    regAddr_d  = regAddr_q;
    regWdata_d = regWdata_q;
    vaddrStb_d = 1'b0;
    vaddr_d    = vaddr_q;
    vaddrWr_d  = vaddrWr_q;
    r16_d      = r16_q;
    r17_d      = r17_q;
    regReq     = 1'b0;
    regIdx     = 6'd0;
    regData    = 8'd0;
`ifdef IKA9958_PALETTE_EN
    plState_d  = plState_q;
    palLatch_d = palLatch_q;
    palWe_d    = 1'b0;
    palIdx_d   = palIdx_q;
    palData_d  = palData_q;
`endif

    if (wrEn && i_PORT == 2'd1) begin
      if (p1State_q == P1_IDLE) begin
        p1Latch_d = i_DIN;
        p1State_d = P1_HAVE1;
      end else begin
        p1State_d = P1_IDLE;
        if (i_DIN[7]) begin
          regReq  = 1'b1;
          regIdx  = i_DIN[5:0];
          regData = p1Latch_q;
        end else begin
          vaddrStb_d = 1'b1;
          vaddr_d    = {i_DIN[5:0], p1Latch_q};
          vaddrWr_d  = i_DIN[6];
        end
      end
    end

    if (rdEn && i_PORT == 2'd1) begin
      p1State_d = P1_IDLE;
    end

    // Indirect port: R17 itself is never a target; the pointer advances even for dropped writes.
    if (wrEn && i_PORT == 2'd3) begin
      if (r17_q[5:0] != 6'd17) begin
        regReq  = 1'b1;
        regIdx  = r17_q[5:0];
        regData = i_DIN;
      end
      if (!r17_q[7]) begin
        r17_d[5:0] = r17_q[5:0] + 6'd1;
      end
    end

`ifdef IKA9958_PALETTE_EN
    if (wrEn && i_PORT == 2'd2) begin
      if (plState_q == PL_IDLE) begin
        palLatch_d = {i_DIN[6:4], i_DIN[2:0]};
        plState_d  = PL_HAVE1;
      end else begin
        plState_d = PL_IDLE;
        palWe_d   = 1'b1;
        palIdx_d  = r16_q;
        palData_d = {palLatch_q[5:3], i_DIN[2:0], palLatch_q[2:0]};
        r16_d     = r16_q + 4'd1;
      end
    end
`endif

    if (regReq && regIdx < 6'd47) begin
      regWe_d    = 1'b1;
      regAddr_d  = regIdx;
      regWdata_d = regData;
      if (regIdx == 6'd16) begin
        r16_d = regData[3:0];
`ifdef IKA9958_PALETTE_EN
        plState_d = PL_IDLE;
`endif
      end
      if (regIdx == 6'd17) begin
        r17_d = {regData[7], 1'b0, regData[5:0]};
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      p1State_q  <= P1_IDLE;
      p1Latch_q  <= 8'd0;
      regWe_q    <= 1'b0;
      regAddr_q  <= 6'd0;
      regWdata_q <= 8'd0;
      vaddrStb_q <= 1'b0;
      vaddr_q    <= 14'd0;
      vaddrWr_q  <= 1'b0;
      r16_q      <= 4'd0;
      r17_q      <= 8'd0;
    end else begin
      p1State_q  <= p1State_d;
      p1Latch_q  <= p1Latch_d;
      regWe_q    <= regWe_d;
      regAddr_q  <= regAddr_d;
      regWdata_q <= regWdata_d;
      vaddrStb_q <= vaddrStb_d;
      vaddr_q    <= vaddr_d;
      vaddrWr_q  <= vaddrWr_d;
      r16_q      <= r16_d;
      r17_q      <= r17_d;
    end
  end

`ifdef IKA9958_PALETTE_EN
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      plState_q  <= PL_IDLE;
      palLatch_q <= 6'd0;
      palWe_q    <= 1'b0;
      palIdx_q   <= 4'd0;
      palData_q  <= 9'd0;
    end else begin
      plState_q  <= plState_d;
      palLatch_q <= palLatch_d;
      palWe_q    <= palWe_d;
      palIdx_q   <= palIdx_d;
      palData_q  <= palData_d;
    end
  end

  assign o_PAL_WE   = palWe_q;
  assign o_PAL_IDX  = palIdx_q;
  assign o_PAL_DATA = palData_q;
`else
  assign o_PAL_WE   = 1'b0;
  assign o_PAL_IDX  = 4'd0;
  assign o_PAL_DATA = 9'd0;
`endif

  assign o_REG_WE    = regWe_q;
  assign o_REG_ADDR  = regAddr_q;
  assign o_REG_WDATA = regWdata_q;
  assign o_VADDR_STB = vaddrStb_q;
  assign o_VADDR     = vaddr_q;
  assign o_VADDR_WR  = vaddrWr_q;
  assign o_R16       = r16_q;
  assign o_R17       = r17_q;

endmodule

// File: doc/ika9958_reg_access_ctrl.md
IKA9958_REG_ACCESS_CTRL -- requirements
Module: ika9958_reg_access_ctrl

Interface
REQ-001 SHALL have port i_EMUCLK  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port i_WR_STB  input  1  one-cycle CPU write strobe.
REQ-004 SHALL have port i_RD_STB  input  1  one-cycle CPU read strobe.
REQ-005 SHALL have port i_PORT  input  2  CPU port number (0..3) qualifying either strobe.
REQ-006 SHALL have port i_DIN  input  8  CPU write data.
REQ-007 SHALL have port o_REG_WE  output  1  one-cycle register-file write enable.
REQ-008 SHALL have port o_REG_ADDR  output  6  register index for o_REG_WE.
REQ-009 SHALL have port o_REG_WDATA  output  8  register data for o_REG_WE.
REQ-010 SHALL have port o_VADDR_STB  output  1  one-cycle VRAM address setup pulse.
REQ-011 SHALL have port o_VADDR  output  14  VRAM address low 14 bits.
REQ-012 SHALL have port o_VADDR_WR  output  1  VRAM access direction (1 = write).
REQ-013 SHALL have port o_PAL_WE  output  1  one-cycle palette write enable.
REQ-014 SHALL have port o_PAL_IDX  output  4  palette entry index.
REQ-015 SHALL have port o_PAL_DATA  output  9  palette colour {R[2:0],G[2:0],B[2:0]}.
REQ-016 SHALL have port o_R16  output  4  palette pointer shadow.
REQ-017 SHALL have port o_R17  output  8  indirect pointer shadow {AII,0,RS[5:0]}.

Function
REQ-018 SHALL implement port-1 FSM P1_IDLE/P1_HAVE1: write in P1_IDLE latches i_DIN, goes P1_HAVE1; write in P1_HAVE1 decodes the second byte, returns P1_IDLE.
REQ-019 Second byte 1x_rrrrrr SHALL produce o_REG_WE, o_REG_ADDR=rrrrrr, o_REG_WDATA=latched byte, exactly 1 cycle after the strobe.
REQ-020 Second byte 0w_aaaaaa SHALL produce o_VADDR_STB, o_VADDR={aaaaaa,latched}, o_VADDR_WR=w, 1 cycle after the strobe.
REQ-021 Register indices 47..63 SHALL be dropped (no o_REG_WE); the FSM still returns P1_IDLE.
REQ-022 Any i_RD_STB with i_PORT=1 SHALL force P1_IDLE, discarding a latched first byte.
REQ-023 i_WR_STB and i_RD_STB asserted together SHALL process only the write.
REQ-024 Accepted writes to R16 or R17 SHALL also load o_R16 (data[3:0]) or o_R17 (data[7], data[5:0]; bit 6 forced 0) in the same cycle as o_REG_WE.
REQ-025 Port-3 write SHALL produce o_REG_WE to o_R17[5:0] with i_DIN after 1 cycle, except index 17 or 47..63, which are dropped.
REQ-026 After any port-3 write, dropped or not, with o_R17[7]=0, o_R17[5:0] SHALL increment modulo 64 (63 wraps to 0); AII=1 SHALL hold it.
REQ-027 SHALL implement palette FSM PL_IDLE/PL_HAVE1 on port-2 writes: first byte latches R=[6:4], B=[2:0]; second supplies G=[2:0].
REQ-028 The second palette byte SHALL produce o_PAL_WE, o_PAL_IDX=o_R16, o_PAL_DATA 1 cycle later, then o_R16 SHALL increment modulo 16 (15 wraps to 0).
REQ-029 An accepted R16 write SHALL force PL_IDLE.
REQ-030 Writes to port 0 SHALL be ignored; reads other than port 1 SHALL have no effect.
REQ-031 o_REG_WE, o_VADDR_STB and o_PAL_WE SHALL be single-cycle pulses and SHALL be 0 whenever their path produced nothing the previous cycle.

Reset
REQ-032 i_RST SHALL set P1_IDLE, PL_IDLE, all pulses 0, o_REG_ADDR=0, o_REG_WDATA=0, o_VADDR=0, o_VADDR_WR=0, o_PAL_IDX=0, o_PAL_DATA=0, o_R16=0, o_R17=0.
REQ-033 i_RST mid-sequence SHALL discard latched first bytes; reset SHALL override a strobe in the same cycle.

Configuration
REQ-034 With macro IKA9958_PALETTE_EN defined, the palette path (REQ-027..029) SHALL be present.
REQ-035 Without IKA9958_PALETTE_EN, port-2 writes SHALL be ignored and o_PAL_WE, o_PAL_IDX, o_PAL_DATA SHALL be held 0; o_R16 still SHALL track R16 writes.

Verification
REQ-036 Port 1 writes 0x06 then 0x80 -> 1 cycle later o_REG_WE=1, o_REG_ADDR=0, o_REG_WDATA=0x06; pulse lasts one cycle.
REQ-037 Port 1 writes 0x34 then 0x52 -> o_VADDR_STB=1, o_VADDR=0x1234, o_VADDR_WR=1; no o_REG_WE.
REQ-038 Port 1 writes 0x55, then port-1 read, then writes 0x02 and 0x89 -> o_REG_WE with o_REG_ADDR=9, o_REG_WDATA=0x02.
REQ-039 R17=0x3F via port 1, then port 3 writes 0xAA, 0xBB -> o_REG_WE to R63 suppressed; R0=0xBB written; o_R17 ends 0x01.
REQ-040 R16=0x0F, then port 2 writes 0x75, 0x03 -> o_PAL_WE, o_PAL_IDX=15, o_PAL_DATA=9'b111_011_101; o_R16 becomes 0.
REQ-041 Port 1 writes 0x11 then 0xAF (R47) -> no o_REG_WE; next pair 0x11, 0x81 -> R1=0x11 written.
